vector_acc_scheduler: RTL and testbench
=======================================

// Module: vector_acc_scheduler
// PURPOSE
//  Sequencer for the unsigned vector accumulator in the corr-matrix path. Tracks sample/vector position
//  of the input stream, pulses new_acc at each integration boundary, and gates the accumulator dump:
//  drops the stale first dump, tags valid dumps with channel index and integration number.
// PARAMETERS
//  VECTOR_LEN     64  samples per vector; power of 2, >=2; must match the accumulator
//  ACC_LEN_WIDTH  16  width of acc_len (vectors per integration)
//  ACC_CNT_WIDTH  32  width of integration counter acc_id
// PORTS
//  clk          in   1                      single clock domain
//  rst_n        in   1                      asynchronous, active-low reset
//  enable       in   1                      run request, level
//  acc_len      in   ACC_LEN_WIDTH          vectors per integration; 0 treated as 1; sampled at boundaries
//  din_valid    in   1                      input sample strobe (same as accumulator din_valid)
//  sync_in      in   1                      marks sample 0 of a vector; qualified by din_valid
//  new_acc      out  1                      one-cycle pulse to accumulator new_acc
//  acc_dout_valid in 1                      accumulator dout_valid
//  dout_valid   out  1                      gated dump valid
//  dout_chan    out  $clog2(VECTOR_LEN)     channel index of current dump sample
//  acc_id       out  ACC_CNT_WIDTH          number of the integration being dumped (first valid = 0)
//  busy         out  1                      state != IDLE
//  misalign_err out  1                      sticky; sync_in seen at nonzero sample position
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; misalign_err cleared only by reset.
//  samp_cnt counts din_valid modulo VECTOR_LEN; vec_cnt counts completed vectors in the integration.
//  States: IDLE -(enable)-> WAIT_SYNC -(din_valid&sync_in)-> PRIME -(vector end)-> FILL
//          -(acc_len vectors done)-> RUN; RUN loops per integration.
//  WAIT_SYNC: the din_valid&sync_in sample is sample 0; samp_cnt<=1. Samples before sync are ignored.
//  Vector end = din_valid at samp_cnt==VECTOR_LEN-1. Boundary = vector end of PRIME, or of vector
//   vec_cnt==len_q-1 in FILL/RUN. At a boundary: new_acc registered high the following cycle, exactly one cycle;
//   vec_cnt<=0; len_q<=max(acc_len,1).
//  Latency: new_acc is 1 cycle after the last sample's din_valid; the accumulator then writes the next
//   vector fresh and dumps the old sums over that vector.
//  Gating: dump following the PRIME boundary (FILL start) is stale -> dout_valid forced 0 for it.
//   Later dumps: dout_valid=acc_dout_valid (combinational AND with mask); dout_chan increments per
//   dout_valid, wraps at VECTOR_LEN; acc_id increments after chan VECTOR_LEN-1, wraps at 2^ACC_CNT_WIDTH.
//  enable low: sampled only at boundaries in FILL/RUN; the boundary new_acc is still issued (final dump
//   emitted), then IDLE. enable low in WAIT_SYNC/PRIME -> IDLE immediately, no new_acc.
//  Re-enable from IDLE restarts at WAIT_SYNC; first dump again suppressed; acc_id continues.
//  sync_in at samp_cnt!=0 (FILL/RUN/PRIME): misalign_err<=1, current sample taken as sample 0
//   (samp_cnt<=1); vec_cnt unchanged. Coincident with a vector-end position: resync wins, no boundary.
//  acc_len changing mid-integration has no effect until the next boundary.
//  Async reset mid-dump: outputs drop immediately; accumulator contents treated as stale on restart.
// CONFIGURATION
//  VACC_SCHED_SYNC_CHECK_EN defined: sync_in checking and misalign_err as above.
//  Not defined: sync_in used only in WAIT_SYNC; later sync_in ignored; misalign_err tied 0.
// STRUCTURE
//  Include file vacc_sched_defs.vh: state encodings (IDLE, WAIT_SYNC, PRIME, FILL, RUN) as localparams.
//  One sub-module: vacc_pos_counter (samp_cnt/vec_cnt with vector-end and boundary flags). FSM and
//  dump gating stay in the top module.
// TESTING
//  1 VECTOR_LEN=8, acc_len=3, continuous valid, sync on first sample -> new_acc 1 cycle after samples
//    7 (PRIME end), 31, 55; first dump masked; second dump dout_valid x8, chan 0..7, acc_id=0.
//  2 din_valid 50% random gaps -> new_acc still exactly 1 cycle after each 24th valid sample; no double pulse.
//  3 acc_len=0 -> behaves as 1: new_acc after every vector end after PRIME.
//  4 sync_in at sample 5 in RUN -> misalign_err=1, next vector end 8 valid samples later;
//    without VACC_SCHED_SYNC_CHECK_EN no effect, err stays 0.
//  5 enable dropped mid-integration -> new_acc at that integration's boundary, final dump, busy=0 after it.
//  6 rst_n low during dump -> dout_valid/new_acc 0 at once; after re-enable first dump masked, acc_id=0.

Source files
------------

// File: rtl/vector_acc_scheduler_pkg.sv
// Shared types for the vector accumulator scheduler.
// Optional sync checking is selected by VACC_SCHED_SYNC_CHECK_EN in the top and counter.
package vector_acc_scheduler_pkg;

   `include "vacc_sched_defs.vh"

   typedef enum logic [2:0] {
      StIdle     = StIdleEnc,
      StWaitSync = StWaitSyncEnc,
      StPrime    = StPrimeEnc,
      StFill     = StFillEnc,
      StRun      = StRunEnc
   } state_e;

endpackage

// File: rtl/vacc_pos_counter.sv
// Sample/vector position tracker: samp_cnt modulo VECTOR_LEN, vec_cnt within an integration.
// VACC_SCHED_SYNC_CHECK_EN adds the samp_zero output used for misalignment detection.
module vacc_pos_counter #(
   parameter int unsigned VECTOR_LEN    = 64,
   parameter int unsigned ACC_LEN_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         start,
   input  logic                         count_en,
   input  logic                         din_valid,
   input  logic                         resync,
   input  logic                         vec_clr,
   input  logic [ACC_LEN_WIDTH-1:0]     len_q,
`ifdef VACC_SCHED_SYNC_CHECK_EN
   output logic                         samp_zero,
`endif
   output logic                         vec_end,
   output logic                         last_vec
);

   localparam int unsigned SampW = $clog2(VECTOR_LEN);

   logic [SampW-1:0]         samp_q, samp_d;
   logic [ACC_LEN_WIDTH-1:0] vec_q, vec_d;
   logic                     at_end;

   always_comb begin
      samp_d   = samp_q;
      vec_d    = vec_q;
      at_end   = (samp_q == SampW'(VECTOR_LEN - 1));
      // A resync on the last position replaces the vector end.
      vec_end  = count_en & din_valid & at_end & ~resync;
      last_vec = (vec_q == len_q - 1'b1);
      if (clear) begin
         samp_d = '0;
         vec_d  = '0;
      end else if (start) begin
         samp_d = SampW'(1);
         vec_d  = '0;
      end else if (count_en && din_valid) begin
         if (resync) begin
            samp_d = SampW'(1);
         end else begin
            samp_d = samp_q + 1'b1;
            if (at_end) begin
               vec_d = vec_clr ? '0 : vec_q + 1'b1;
            end
         end
      end
   end

`ifdef VACC_SCHED_SYNC_CHECK_EN
   assign samp_zero = (samp_q == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_q <= '0;
         vec_q  <= '0;
      end else begin
         samp_q <= samp_d;
         vec_q  <= vec_d;
      end
   end

endmodule

// File: rtl/vacc_sched_defs.vh
// State encodings for the vector accumulator scheduler FSM.
// Included inside vector_acc_scheduler_pkg only.
localparam logic [2:0] StIdleEnc     = 3'd0;
localparam logic [2:0] StWaitSyncEnc = 3'd1;
localparam logic [2:0] StPrimeEnc    = 3'd2;
localparam logic [2:0] StFillEnc     = 3'd3;
localparam logic [2:0] StRunEnc      = 3'd4;

// File: rtl/vector_acc_scheduler.sv
// Sequencer for the unsigned vector accumulator: new_acc generation and dump gating/tagging.
// Define VACC_SCHED_SYNC_CHECK_EN to enable mid-stream sync_in checking and misalign_err.
module vector_acc_scheduler
   import vector_acc_scheduler_pkg::*;
#(
   parameter int unsigned VECTOR_LEN    = 64,
   parameter int unsigned ACC_LEN_WIDTH = 16,
   parameter int unsigned ACC_CNT_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [ACC_LEN_WIDTH-1:0]      acc_len,
   input  logic                          din_valid,
   input  logic                          sync_in,
   output logic                          new_acc,
   input  logic                          acc_dout_valid,
   output logic                          dout_valid,
   output logic [$clog2(VECTOR_LEN)-1:0] dout_chan,
   output logic [ACC_CNT_WIDTH-1:0]      acc_id,
   output logic                          busy,
   output logic                          misalign_err
);

   localparam int unsigned ChanW = $clog2(VECTOR_LEN);

   state_e                   state_q, state_d;
   logic [ACC_LEN_WIDTH-1:0] len_q, len_d;
   logic                     new_acc_q, new_acc_d;
   logic                     primed_q, primed_d;
   logic                     skip_q, skip_d;
   logic [ChanW-1:0]         chan_q, chan_d;
   logic [ACC_CNT_WIDTH-1:0] id_q, id_d;

   logic in_active, start, resync, vec_end, last_vec, boundary;

   assign in_active = (state_q == StPrime) || (state_q == StFill) || (state_q == StRun);
   assign boundary  = vec_end & ((state_q == StPrime) | last_vec);

`ifdef VACC_SCHED_SYNC_CHECK_EN
   logic samp_zero;
   logic err_q, err_d;

   assign resync = in_active & din_valid & sync_in & ~samp_zero;

   always_comb begin
      err_d = err_q | resync;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign misalign_err = err_q;
`else
   assign resync       = 1'b0;
   assign misalign_err = 1'b0;
`endif

   vacc_pos_counter #(
      .VECTOR_LEN    (VECTOR_LEN),
      .ACC_LEN_WIDTH (ACC_LEN_WIDTH)
   ) u_pos_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state_q == StIdle),
      .start     (start),
      .count_en  (in_active),
      .din_valid (din_valid),
      .resync    (resync),
      .vec_clr   (new_acc_d),
      .len_q     (len_q),
`ifdef VACC_SCHED_SYNC_CHECK_EN
      .samp_zero (samp_zero),
`endif
      .vec_end   (vec_end),
      .last_vec  (last_vec)
   );

   always_comb begin
      state_d   = state_q;
      new_acc_d = 1'b0;
      len_d     = len_q;
      start     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StWaitSync;
         end
         StWaitSync: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (din_valid && sync_in) begin
               state_d = StPrime;
               start   = 1'b1;
            end
         end
         StPrime: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (boundary) begin
               state_d   = StFill;
               new_acc_d = 1'b1;
            end
         end
         StFill, StRun: begin
            // enable only matters here at a boundary, so the final dump is always requested.
            if (boundary) begin
               new_acc_d = 1'b1;
               state_d   = enable ? StRun : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (new_acc_d) begin
         len_d = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
      end
   end

   always_comb begin
      primed_d = primed_q;
      skip_d   = skip_q;
      chan_d   = chan_q;
      id_d     = id_q;
      if (primed_q && acc_dout_valid) begin
         chan_d = chan_q + 1'b1;
         if (chan_q == ChanW'(VECTOR_LEN - 1)) begin
            if (skip_q) skip_d = 1'b0;
            else        id_d   = id_q + 1'b1;
         end
      end
      // The dump right after the PRIME boundary holds sums from before the stream was aligned.
      if ((state_q == StPrime) && new_acc_d) begin
         primed_d = 1'b1;
         skip_d   = 1'b1;
         chan_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         len_q     <= '0;
         new_acc_q <= 1'b0;
         primed_q  <= 1'b0;
         skip_q    <= 1'b0;
         chan_q    <= '0;
         id_q      <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         new_acc_q <= new_acc_d;
         primed_q  <= primed_d;
         skip_q    <= skip_d;
         chan_q    <= chan_d;
         id_q      <= id_d;
      end
   end

   assign new_acc    = new_acc_q;
   assign dout_valid = acc_dout_valid & primed_q & ~skip_q;
   assign dout_chan  = chan_q;
   assign acc_id     = id_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_vector_acc_scheduler.sv
// Directed bench for vector_acc_scheduler with VECTOR_LEN=8 and a minimal accumulator dump model.
// Test 4 expectations follow VACC_SCHED_SYNC_CHECK_EN.
module tb_vector_acc_scheduler;

   localparam int VL = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] acc_len = '0;
   logic        din_valid = 1'b0;
   logic        sync_in = 1'b0;
   logic        new_acc;
   logic        acc_dout_valid = 1'b0;
   logic        dout_valid;
   logic [2:0]  dout_chan;
   logic [31:0] acc_id;
   logic        busy;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;
   int vidx = 0;
   int dump_rem = 0;
   int na_log[$];
   int chan_log[$];
   int id_log[$];
   int exp_q[$];
   int cyc;

   vector_acc_scheduler #(
      .VECTOR_LEN    (VL),
      .ACC_LEN_WIDTH (16),
      .ACC_CNT_WIDTH (32)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .acc_len        (acc_len),
      .din_valid      (din_valid),
      .sync_in        (sync_in),
      .new_acc        (new_acc),
      .acc_dout_valid (acc_dout_valid),
      .dout_valid     (dout_valid),
      .dout_chan      (dout_chan),
      .acc_id         (acc_id),
      .busy           (busy),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One cycle: the dump model replays one vector of sums on the valid samples after new_acc.
   task automatic drive(input logic dv, input logic sy);
      @(negedge clk);
      din_valid      = dv;
      sync_in        = sy;
      acc_dout_valid = dv && (dump_rem > 0);
      if (dv && (dump_rem > 0)) dump_rem--;
      #1;
      if (dout_valid) begin
         chan_log.push_back(int'(dout_chan));
         id_log.push_back(int'(acc_id));
      end
      @(posedge clk);
      #1;
      if (new_acc) begin
         na_log.push_back(dv ? vidx : -1);
         dump_rem = VL;
      end
      if (dv) vidx++;
   endtask

   task automatic do_reset(input logic [15:0] len);
      rst_n = 1'b0;
      enable = 1'b0;
      din_valid = 1'b0;
      sync_in = 1'b0;
      acc_dout_valid = 1'b0;
      acc_len = len;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      vidx = 0;
      dump_rem = 0;
      na_log.delete();
      chan_log.delete();
      id_log.delete();
   endtask

   task automatic start_run();
      enable = 1'b1;
      drive(1'b0, 1'b0);
   endtask

   task automatic run_samples(input int last);
      while (vidx <= last) drive(1'b1, vidx == 0);
   endtask

   task automatic check_na(input string tag, input int e[$]);
      check({tag, "_count"}, na_log.size(), e.size());
      foreach (e[i]) check(tag, (i < na_log.size()) ? na_log[i] : -1, e[i]);
   endtask

   task automatic check_dumps(input string tag, input int n);
      check({tag, "_count"}, chan_log.size(), n);
      for (int i = 0; i < n && i < chan_log.size(); i++) begin
         check({tag, "_chan"}, chan_log[i], i % VL);
         check({tag, "_id"}, id_log[i], i / VL);
      end
   endtask

   initial begin
      // Reset state
      do_reset(16'd3);
      check("rst_new_acc", new_acc, 0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_misalign", misalign_err, 0);
      check("rst_acc_id", acc_id, 0);
      check("rst_chan", dout_chan, 0);

      // 1: acc_len=3, continuous valid
      start_run();
      check("t1_busy", busy, 1);
      run_samples(63);
      exp_q = '{7, 31, 55};
      check_na("t1_new_acc", exp_q);
      check_dumps("t1_dump", 16);

      // 2: random gaps, acc_len=3
      do_reset(16'd3);
      start_run();
      cyc = 0;
      while (vidx < 80 && cyc < 1000) begin
         logic dv;
         dv = 1'($urandom_range(0, 1));
         drive(dv, dv && (vidx == 0));
         cyc++;
      end
      check("t2_done", vidx, 80);
      exp_q = '{7, 31, 55, 79};
      check_na("t2_new_acc", exp_q);

      // 3: acc_len=0 acts as 1
      do_reset(16'd0);
      start_run();
      run_samples(31);
      exp_q = '{7, 15, 23, 31};
      check_na("t3_new_acc", exp_q);

      // 4: sync_in at sample 5 of the first RUN vector (index 29)
      do_reset(16'd2);
      start_run();
      run_samples(28);
      check("t4_err_before", misalign_err, 0);
      drive(1'b1, 1'b1);
      run_samples(47);
`ifdef VACC_SCHED_SYNC_CHECK_EN
      check("t4_err_after", misalign_err, 1);
      exp_q = '{7, 23, 44};
`else
      check("t4_err_after", misalign_err, 0);
      exp_q = '{7, 23, 39};
`endif
      check_na("t4_new_acc", exp_q);

      // 5: enable dropped mid-integration
      do_reset(16'd2);
      start_run();
      run_samples(29);
      enable = 1'b0;
      run_samples(38);
      check("t5_busy_pre", busy, 1);
      run_samples(39);
      check("t5_busy_post", busy, 0);
      run_samples(55);
      exp_q = '{7, 23, 39};
      check_na("t5_new_acc", exp_q);
      check_dumps("t5_dump", 16);
      check("t5_last_id", (id_log.size() > 0) ? id_log[id_log.size() - 1] : -1, 1);

      // 6: async reset while a dump sample and new_acc are high
      do_reset(16'd1);
      start_run();
      run_samples(15);
      @(negedge clk);
      din_valid = 1'b1;
      acc_dout_valid = 1'b1;
      #1;
      check("t6_dv_pre", dout_valid, 1);
      check("t6_na_pre", new_acc, 1);
      rst_n = 1'b0;
      #1;
      check("t6_dv_rst", dout_valid, 0);
      check("t6_na_rst", new_acc, 0);
      check("t6_busy_rst", busy, 0);
      check("t6_id_rst", acc_id, 0);
      din_valid = 1'b0;
      acc_dout_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      vidx = 0;
      dump_rem = 0;
      na_log.delete();
      chan_log.delete();
      id_log.delete();
      start_run();
      run_samples(23);
      exp_q = '{7, 15, 23};
      check_na("t6_new_acc", exp_q);
      check_dumps("t6_dump", 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
